// File: rtl/alu_pkg.sv
// Shared types and helpers for the ALU datapath slices.
package alu_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Width of a counter that indexes k items; never narrower than one bit.
  function automatic int idx_width(input int k);
    int w;
    w = 1;
    while ((1 << w) < k) w++;
    return w;
  endfunction

endpackage

// File: rtl/add_chunk.sv
// Combinational W-bit adder slice with carry in/out.
module add_chunk #(
  parameter int W = 8
) (
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         Cin,
  output logic [W-1:0] S,
  output logic         Cout
);

  assign {Cout, S} = {1'b0, A} + {1'b0, B} + {{W{1'b0}}, Cin};

endmodule

// File: rtl/seq_add_sub.sv
// Multi-cycle N-bit adder/subtractor: one CHUNK-wide slice per clock with a
// registered carry, valid/ready on both sides, signed-overflow and zero flags.
module seq_add_sub
  import alu_pkg::*;
#(
  parameter int N     = 32,
  parameter int CHUNK = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic         zero
);

  localparam int K  = N / CHUNK;
  localparam int IW = idx_width(K);
  localparam logic [IW-1:0] LAST_IDX = IW'(K - 1);

  if (N % CHUNK != 0) begin : g_chunk_check
    $error("seq_add_sub: N must be a multiple of CHUNK");
  end

  state_t           state_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [N-1:0]     a_q;
  logic [N-1:0]     b_q;
  logic [N-1:0]     sum_q;
  logic             carry_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;
  logic [IW-1:0]    idx_q;

  logic [CHUNK-1:0] chunk_a;
  logic [CHUNK-1:0] chunk_b;
  logic [CHUNK-1:0] chunk_s;
  logic             chunk_c;
  logic [N-1:0]     sum_d;

  assign chunk_a = a_q[int'(idx_q)*CHUNK +: CHUNK];
  assign chunk_b = b_q[int'(idx_q)*CHUNK +: CHUNK];

  add_chunk #(.W(CHUNK)) u_add_chunk (
    .A    (chunk_a),
    .B    (chunk_b),
    .Cin  (carry_q),
    .S    (chunk_s),
    .Cout (chunk_c)
  );

  // Result with the current slice merged in, so the final-slice flags see the full word.
  always_comb begin
    sum_d = sum_q;
    sum_d[int'(idx_q)*CHUNK +: CHUNK] = chunk_s;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= a;
            b_q        <= (sub == OP_ADD) ? b : ~b;
            carry_q    <= (sub == OP_SUB);
            idx_q      <= '0;
            sum_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          sum_q   <= sum_d;
          carry_q <= chunk_c;
          idx_q   <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            cout_q      <= chunk_c;
            // b_q is already inverted for subtract, so this is the A+B' overflow rule.
            ovf_q       <= (a_q[N-1] == b_q[N-1]) && (sum_d[N-1] != a_q[N-1]);
            zero_q      <= (sum_d == '0);
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_seq_add_sub.sv
// Bench for seq_add_sub: three configurations (32/8, 8/8, 16/4) checked
// against an arithmetic reference model every cycle, plus literal expectations.
module tb_seq_add_sub;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  in_valid = '0;
  logic [2:0]  out_ready = '0;
  logic [2:0]  sub_r = '0;
  logic [31:0] a_r [3];
  logic [31:0] b_r [3];
  logic [2:0]  in_ready_w;
  logic [2:0]  out_valid_w;
  logic [2:0]  cout_w;
  logic [2:0]  ovf_w;
  logic [2:0]  zero_w;
  logic [31:0] sum_w [3];
  logic [31:0] s0;
  logic [7:0]  s1;
  logic [15:0] s2;

  int total = 0;
  int bad = 0;

  int   mst [3];
  int   mcnt [3];
  res_t exp_r [3];
  bit   rst_prev = 1'b0;

  always #5 clk = ~clk;

  assign sum_w[0] = s0;
  assign sum_w[1] = {24'd0, s1};
  assign sum_w[2] = {16'd0, s2};

  seq_add_sub #(.N(32), .CHUNK(8)) dut0 (
    .clk(clk), .reset(rst), .in_valid(in_valid[0]), .in_ready(in_ready_w[0]),
    .a(a_r[0]), .b(b_r[0]), .sub(sub_r[0]), .out_valid(out_valid_w[0]),
    .out_ready(out_ready[0]), .sum(s0), .cout(cout_w[0]), .ovf(ovf_w[0]), .zero(zero_w[0])
  );

  seq_add_sub #(.N(8), .CHUNK(8)) dut1 (
    .clk(clk), .reset(rst), .in_valid(in_valid[1]), .in_ready(in_ready_w[1]),
    .a(a_r[1][7:0]), .b(b_r[1][7:0]), .sub(sub_r[1]), .out_valid(out_valid_w[1]),
    .out_ready(out_ready[1]), .sum(s1), .cout(cout_w[1]), .ovf(ovf_w[1]), .zero(zero_w[1])
  );

  seq_add_sub #(.N(16), .CHUNK(4)) dut2 (
    .clk(clk), .reset(rst), .in_valid(in_valid[2]), .in_ready(in_ready_w[2]),
    .a(a_r[2][15:0]), .b(b_r[2][15:0]), .sub(sub_r[2]), .out_valid(out_valid_w[2]),
    .out_ready(out_ready[2]), .sum(s2), .cout(cout_w[2]), .ovf(ovf_w[2]), .zero(zero_w[2])
  );

  function automatic int n_of(input int i);
    return (i == 0) ? 32 : (i == 1) ? 8 : 16;
  endfunction

  function automatic int k_of(input int i);
    return (i == 1) ? 1 : 4;
  endfunction

  // Reference: plain integer arithmetic on the unsigned and signed readings.
  function automatic res_t model(input int n, input logic [31:0] av, input logic [31:0] bv,
                                 input logic s);
    longint full, lim, ua, ub, sa, sb, sr, raw;
    res_t r;
    full = longint'(1) << n;
    lim  = full / 2;
    ua   = longint'(av) & (full - 1);
    ub   = longint'(bv) & (full - 1);
    raw  = s ? (ua - ub) : (ua + ub);
    sa   = (ua >= lim) ? ua - full : ua;
    sb   = (ub >= lim) ? ub - full : ub;
    sr   = s ? (sa - sb) : (sa + sb);
    r.sum  = 32'(raw & (full - 1));
    r.cout = s ? (ua >= ub) : ((ua + ub) >= full);
    r.ovf  = (sr >= lim) || (sr < -lim);
    r.zero = ((raw & (full - 1)) == 0);
    return r;
  endfunction

  task automatic check32(input string nm, input int inst, input logic [31:0] act,
                         input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst%0d t=%0t actual=%h required=%h", nm, inst, $time, act, exp);
    end
  endtask

  task automatic check1(input string nm, input int inst, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst%0d t=%0t actual=%b required=%b", nm, inst, $time, act, exp);
    end
  endtask

  // Compare process: model state 0=idle, 1=computing, 2=holding a result.
  initial begin
    for (int i = 0; i < 3; i++) begin
      mst[i] = 0;
      mcnt[i] = 0;
      exp_r[i] = '0;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst_prev) begin
        check1("rst_in_ready", i, in_ready_w[i], 1'b1);
        check1("rst_out_valid", i, out_valid_w[i], 1'b0);
        check32("rst_sum", i, sum_w[i], 32'd0);
        check1("rst_flags", i, cout_w[i] | ovf_w[i] | zero_w[i], 1'b0);
      end
      check1("in_ready", i, in_ready_w[i], mst[i] == 0);
      check1("out_valid", i, out_valid_w[i], mst[i] == 2);
      if (mst[i] == 2) begin
        check32("sum", i, sum_w[i], exp_r[i].sum);
        check1("cout", i, cout_w[i], exp_r[i].cout);
        check1("ovf", i, ovf_w[i], exp_r[i].ovf);
        check1("zero", i, zero_w[i], exp_r[i].zero);
      end
      if (rst) begin
        mst[i] = 0;
      end else begin
        case (mst[i])
          0: if (in_valid[i]) begin
            exp_r[i] = model(n_of(i), a_r[i], b_r[i], sub_r[i]);
            mst[i] = 1;
            mcnt[i] = 0;
          end
          1: begin
            mcnt[i]++;
            if (mcnt[i] == k_of(i)) mst[i] = 2;
          end
          default: if (out_ready[i]) begin
            $display("txn inst%0d sum=%h cout=%b ovf=%b zero=%b", i, sum_w[i], cout_w[i],
                     ovf_w[i], zero_w[i]);
            mst[i] = 0;
          end
        endcase
      end
    end
    rst_prev = rst;
  end

  // Present an op, wait for accept and result; returns with out_ready still low.
  task automatic send(input int i, input logic [31:0] av, input logic [31:0] bv,
                      input logic s, output res_t r);
    int n;
    @(posedge clk); #1;
    a_r[i] = av; b_r[i] = bv; sub_r[i] = s; in_valid[i] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!in_ready_w[i] && n < 50);
    check1("accept_timeout", i, in_ready_w[i], 1'b1);
    @(posedge clk); #1;
    in_valid[i] = 1'b0;
    a_r[i] = $urandom; b_r[i] = $urandom; sub_r[i] = ~s;
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid_w[i] && n < 50);
    check32("latency", i, n, k_of(i) + 1);
    r.sum = sum_w[i]; r.cout = cout_w[i]; r.ovf = ovf_w[i]; r.zero = zero_w[i];
  endtask

  task automatic release_result(input int i, input int hold);
    repeat (hold) @(posedge clk);
    @(posedge clk); #1;
    out_ready[i] = 1'b1;
    @(posedge clk); #1;
    out_ready[i] = 1'b0;
  endtask

  task automatic expect_res(input string nm, input res_t r, input logic [31:0] es,
                            input logic ec, input logic eo, input logic ez);
    check32({nm, "_sum"}, 0, r.sum, es);
    check1({nm, "_cout"}, 0, r.cout, ec);
    check1({nm, "_ovf"}, 0, r.ovf, eo);
    check1({nm, "_zero"}, 0, r.zero, ez);
  endtask

  initial begin
    res_t r;
    int   n;
    for (int i = 0; i < 3; i++) begin
      a_r[i] = '0;
      b_r[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    send(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, r);
    expect_res("add_wrap", r, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    release_result(0, 0);
    send(0, 32'h0000_0005, 32'h0000_0007, 1'b1, r);
    expect_res("sub_borrow", r, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    release_result(0, 1);
    send(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, r);
    expect_res("add_ovf", r, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    release_result(0, 0);
    send(0, 32'h8000_0000, 32'h0000_0001, 1'b1, r);
    expect_res("sub_ovf", r, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    release_result(0, 2);

    // Backpressure: a new op waits while the result is held.
    send(0, 32'h1234_5678, 32'h1111_1111, 1'b0, r);
    expect_res("bp_first", r, 32'h2345_6789, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    a_r[0] = 32'd3; b_r[0] = 32'd4; sub_r[0] = 1'b0; in_valid[0] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check1("bp_in_ready", 0, in_ready_w[0], 1'b0);
      check1("bp_out_valid", 0, out_valid_w[0], 1'b1);
      check32("bp_hold_sum", 0, sum_w[0], 32'h2345_6789);
    end
    @(posedge clk); #1 out_ready[0] = 1'b1;
    @(posedge clk); #1 out_ready[0] = 1'b0;
    @(negedge clk);
    check1("bp_idle", 0, in_ready_w[0], 1'b1);
    check1("bp_idle_ov", 0, out_valid_w[0], 1'b0);
    @(posedge clk); #1 in_valid[0] = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid_w[0] && n < 50);
    check32("bp_second_sum", 0, sum_w[0], 32'd7);
    release_result(0, 0);

    // Reset on the second computing edge discards the op.
    @(posedge clk); #1;
    a_r[0] = 32'd1; b_r[0] = 32'd2; sub_r[0] = 1'b0; in_valid[0] = 1'b1;
    @(negedge clk);
    check1("rm_ready", 0, in_ready_w[0], 1'b1);
    @(posedge clk); #1 in_valid[0] = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check1("rm_in_ready", 0, in_ready_w[0], 1'b1);
    check1("rm_out_valid", 0, out_valid_w[0], 1'b0);
    check32("rm_sum", 0, sum_w[0], 32'd0);
    repeat (8) begin
      @(negedge clk);
      check1("rm_no_stale", 0, out_valid_w[0], 1'b0);
    end

    // Single-chunk configuration.
    send(1, 32'h0000_0080, 32'h0000_0001, 1'b1, r);
    check32("k1_sum", 1, r.sum, 32'h0000_007F);
    check1("k1_ovf", 1, r.ovf, 1'b1);
    check1("k1_cout", 1, r.cout, 1'b1);
    release_result(1, 0);

    // Random ops on the 16/4 configuration with random consumer delay.
    for (int t = 0; t < 1000; t++) begin
      send(2, {16'd0, 16'($urandom)}, {16'd0, 16'($urandom)}, 1'($urandom_range(0, 1)), r);
      release_result(2, $urandom_range(0, 3));
    end

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_add_sub.md
Name: seq_add_sub

Overview:
- Multi-cycle, parametrised N-bit adder/subtractor for the datapath.
- Processes CHUNK bits per clock and registers the carry between chunks, trading latency for a short critical path.
- Adds a subtract mode, signed-overflow and zero flags, and a valid/ready handshake on both sides.
- Intended for ALU slices where a full-width ripple carry cannot close timing.

Parameters:
- N, 32, operand/result width in bits.
- CHUNK, 8, bits added per cycle; N % CHUNK == 0 is required (elaboration-time assertion).
- K (localparam), N/CHUNK, number of chunk cycles.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operands and op are valid.
- in_ready  out  1  block can accept an operation.
- a  in  N  operand A.
- b  in  N  operand B.
- sub  in  1  0: A+B, 1: A-B (A + ~B + 1).
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- sum  out  N  result.
- cout  out  1  final carry out; for sub, 1 means no borrow.
- ovf  out  1  two's-complement signed overflow.
- zero  out  1  sum == 0.

Behaviour:
- States: IDLE, BUSY, DONE. Reset state is IDLE.
- Reset values: in_ready=1 (IDLE decode), out_valid=0, sum=0, cout=0, ovf=0, zero=0, chunk index=0, carry=0.
- IDLE:
  - in_ready=1.
  - On the edge where in_valid=1, register: a_q=a; b_q = sub ? ~b : b; carry=sub; idx=0; clear sum. Go to BUSY.
- BUSY:
  - in_ready=0, out_valid=0.
  - Each edge adds a_q[idx*CHUNK +: CHUNK] + b_q[same] + carry, writes that sum slice, updates carry, and increments idx.
  - On the edge processing idx==K-1: register cout=carry_out, ovf=(a_q[N-1]==b_q[N-1]) && (new sum[N-1]!=a_q[N-1]), zero=(final sum==0). Go to DONE.
- DONE:
  - out_valid=1, in_ready=0.
  - sum, cout, ovf and zero stay stable until the edge where out_ready=1, then go to IDLE.
- Latency: out_valid first observed after exactly K edges following the accepting edge. K=1 is legal (CHUNK==N).
- Throughput: at most one op per K+2 cycles. In DONE, in_ready=0, so a result handoff and a new accept never happen on the same edge.
- in_valid while not IDLE: ignored; the upstream must hold it until in_ready.
- Operand inputs are sampled only on the accepting edge; later changes have no effect.
- sum and flags are held after handoff until the next accept; they are qualified only by out_valid.
- Reset asserted in any state, including mid-BUSY: next state IDLE, in-flight op discarded, no out_valid pulse, all outputs return to reset values.
- All arithmetic is unsigned modulo 2^N. ovf applies to the signed interpretation only.

Decomposition:
- Shared package alu_pkg:
  - state enum {IDLE, BUSY, DONE}.
  - op constants OP_ADD=0, OP_SUB=1.
  - function for ceil-log2 of K (sizing idx).
- Sub-module add_chunk:
  - Combinational, parameter W, ports A[W], B[W], Cin, S[W], Cout.
  - Instantiated once, with W=CHUNK, and time-multiplexed across chunks.
- Top-level holds the FSM, operand, carry and result registers.

Test Plan (N=32, CHUNK=8 unless noted):
- Add 0xFFFFFFFF + 0x00000001 -> sum=0x00000000, cout=1, zero=1, ovf=0; out_valid rises exactly 4 edges after accept.
- Sub 0x00000005 - 0x00000007 -> sum=0xFFFFFFFE, cout=0, ovf=0, zero=0.
- Add 0x7FFFFFFF + 0x00000001 -> sum=0x80000000, ovf=1, cout=0. Sub 0x80000000 - 0x00000001 -> sum=0x7FFFFFFF, ovf=1, cout=1.
- Backpressure:
  - Hold out_ready=0 for 3 cycles in DONE while driving in_valid=1 with a new op.
  - Required: outputs stable, in_ready=0, new op not accepted.
  - After out_ready=1: IDLE, then new op accepted on the next in_valid edge.
- Reset mid-op:
  - Assert reset for 1 cycle on the 2nd BUSY edge.
  - Required: next cycle state IDLE, in_ready=1, out_valid=0, sum=0; no stale result ever appears.
- Parameter sweep N=8, CHUNK=8 (K=1): sub 0x80 - 0x01 -> sum=0x7F, ovf=1, cout=1, out_valid 1 edge after accept. Also run N=16, CHUNK=4 against a random reference model (1000 ops, random out_ready).
